// File: rtl/keypad_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : keypad_pkg                                         |
// | Description : Shared types, constants and helper functions for   |
// |               the 4x4 matrix keypad scanner / mode decoder.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package keypad_pkg;

  // Scanner FSM: scanning columns, debouncing a candidate, waiting for release
  typedef enum logic [1:0] {
    SCAN = 2'd0,
    DEB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Mode code selecting unfiltered pass-through
  localparam logic [4:0] C_BYPASS    = 5'h10;
  // Column drive after reset: column 0 pulled low
  localparam logic [3:0] C_COL_RESET = 4'b1110;
  // Code emitted for the '*' key
  localparam logic [3:0] C_KEY_STAR  = 4'hE;
  // Rows released / nothing pressed
  localparam logic [3:0] C_ROWS_IDLE = 4'hF;

  // Key code lookup indexed by {row[1:0], col[1:0]}
  localparam logic [3:0] C_KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,   // row 0: 1 2 3 A
    4'h4, 4'h5, 4'h6, 4'hB,   // row 1: 4 5 6 B
    4'h7, 4'h8, 4'h9, 4'hC,   // row 2: 7 8 9 C
    4'hE, 4'h0, 4'hF, 4'hD    // row 3: * 0 # D
  };

  // Index of the lowest-numbered low bit; lower rows win on multi-press
  function automatic logic [1:0] first_low(input logic [3:0] v_n);
    logic [1:0] idx;
    casez (v_n)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Advance the one-cold column drive: 1110 -> 1101 -> 1011 -> 0111 -> 1110
  function automatic logic [3:0] rotate_col(input logic [3:0] col_n);
    return {col_n[2:0], col_n[3]};
  endfunction

  // Mode code after accepting a key: digits select a filter, '*' bypasses,
  // letters and '#' keep the current mode
  function automatic logic [4:0] next_bcd(input logic [3:0] code,
                                          input logic [4:0] cur);
    logic [4:0] res;
    if (code <= 4'd9) begin
      res = {1'b0, code};
    end else if (code == C_KEY_STAR) begin
      res = C_BYPASS;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_mode_scan_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : keypad_mode_scan_if                                |
// | Description : Keypad pins plus decoded mode outputs. The master  |
// |               side is the scanner, the slave side is the board   |
// |               keypad together with the filter selection logic.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface keypad_mode_scan_if;

  logic [3:0] row_n;      // keypad rows, active-low, pulled up
  logic [3:0] col_n;      // column drive, one-cold
  logic [4:0] bcd_data;   // latched filter-mode code
  logic       key_valid;  // one-cycle strobe per accepted key
  logic [3:0] key_code;   // raw code of the last accepted key

  modport master (
    input  row_n,
    output col_n,
    output bcd_data,
    output key_valid,
    output key_code
  );

  modport slave (
    output row_n,
    input  col_n,
    input  bcd_data,
    input  key_valid,
    input  key_code
  );

endinterface
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sync2                                              |
// | Description : Parameterised-width two-flop synchroniser. Resets  |
// |               to all-ones so idle pulled-up lines read released. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops resolve metastability on the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_mode_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : keypad_mode_scan                                   |
// | Description : Scans a 4x4 active-low keypad, debounces the row   |
// |               pattern of the driven column and decodes each      |
// |               accepted press into a key code and filter mode.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module keypad_mode_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_mode_scan_if.master kp_io
);

  // One shared counter sized for the longer of the two intervals
  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] C_SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] C_DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  // Reject parameter values the counter/sync timing cannot support
  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_mode_scan: SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("keypad_mode_scan: DEBOUNCE_CYC must be >= 2");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       col_q,   col_d;
  logic [3:0]       pat_q,   pat_d;
  logic [4:0]       bcd_q,   bcd_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q,  code_d;

  logic [3:0]       rows_s;
  logic [3:0]       w_key_sel;
  logic             w_scan_end;
  logic             w_deb_end;
  logic             w_rows_idle;

  // Rows arrive from the board asynchronously; all decisions use rows_s
  sync2 #(
    .WIDTH (4)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (kp_io.row_n),
    .q_o   (rows_s)
  );

  assign w_scan_end  = (cnt_q == C_SCAN_LAST);
  assign w_deb_end   = (cnt_q == C_DEB_LAST);
  assign w_rows_idle = (rows_s == C_ROWS_IDLE);

  // Key under the held column; the lowest low row wins on multi-press
  assign w_key_sel = C_KEY_MAP[{first_low(pat_q), first_low(col_q)}];

  // State register and all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      cnt_q   <= '0;
      col_q   <= C_COL_RESET;
      pat_q   <= C_ROWS_IDLE;
      bcd_q   <= C_BYPASS;
      valid_q <= 1'b0;
      code_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN: begin
        if (w_scan_end && !w_rows_idle) begin
          state_d = DEB;
        end
      end
      DEB: begin
        if (rows_s != pat_q) begin
          state_d = SCAN;
        end else if (w_deb_end) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (w_rows_idle && w_deb_end) begin
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Counter, column drive and decoded outputs for the next cycle;
  // the counter is cleared on every state change and column advance
  always_comb begin
    cnt_d   = cnt_q + C_CNT_ONE;
    col_d   = col_q;
    pat_d   = pat_q;
    valid_d = 1'b0;
    code_d  = code_q;
    bcd_d   = bcd_q;
    case (state_q)
      SCAN: begin
        if (w_scan_end) begin
          cnt_d = '0;
          if (w_rows_idle) begin
            col_d = rotate_col(col_q);
          end else begin
            pat_d = rows_s;
          end
        end
      end
      DEB: begin
        if (rows_s != pat_q) begin
          // Bounce or glitch: abandon this column and move on
          cnt_d = '0;
          col_d = rotate_col(col_q);
        end else if (w_deb_end) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          code_d  = w_key_sel;
          bcd_d   = next_bcd(w_key_sel, bcd_q);
        end
      end
      HOLD: begin
        if (!w_rows_idle) begin
          // Any activity restarts the release timer, so a short
          // release-then-press is treated as still held
          cnt_d = '0;
        end else if (w_deb_end) begin
          cnt_d = '0;
          col_d = rotate_col(col_q);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign kp_io.col_n     = col_q;
  assign kp_io.bcd_data  = bcd_q;
  assign kp_io.key_valid = valid_q;
  assign kp_io.key_code  = code_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_mode_scan.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_keypad_mode_scan                                |
// | Description : Scoreboard bench for keypad_mode_scan. A keypad    |
// |               model turns pressed keys into row levels from the  |
// |               driven column; expected pulses are queued by the   |
// |               stimulus and consumed by an output monitor.        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_keypad_mode_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 8;

  typedef struct packed {
    logic [3:0] code;
    logic [4:0] bcd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] pressed;   // bit index = row*4 + col
  logic [3:0]  row_v;
  exp_t        sb_q[$];
  int          checks;
  int          errors;

  keypad_mode_scan_if kp ();

  keypad_mode_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp_io (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a row reads low when a pressed key joins it to a low column
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && (kp.col_n[c] === 1'b0)) row_v[r] = 1'b0;
      end
    end
  end
  assign kp.row_n = row_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] code, input logic [4:0] bcd);
    exp_t e;
    e.code = code;
    e.bcd  = bcd;
    sb_q.push_back(e);
  endtask

  // Wait until the given column has just become active (start of its slot)
  task automatic wait_col_start(input logic [3:0] col);
    int n;
    n = 0;
    while (kp.col_n == col && n < 64) begin tick(1); n++; end
    while (kp.col_n != col && n < 64) begin tick(1); n++; end
    check("col_slot_wait", 32'(kp.col_n), 32'(col));
  endtask

  // Press, hold 40 cycles, require the queued pulse, release and settle
  task automatic press_expect(input string name, input logic [15:0] mask,
                              input logic [3:0] code, input logic [4:0] bcd);
    push(code, bcd);
    pressed = mask;
    tick(40);
    check(name, 32'(sb_q.size()), 32'd0);
    pressed = '0;
    tick(16);
  endtask

  // Monitor: every key_valid must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && kp.key_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got key_code %0h bcd %0h expected no pulse",
                 kp.key_code, kp.bcd_data);
      end else begin
        e = sb_q.pop_front();
        check("pulse_code", 32'(kp.key_code), 32'(e.code));
        check("pulse_bcd",  32'(kp.bcd_data), 32'(e.bcd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] prev;
    logic [3:0] exp_col;
    int         n;

    checks  = 0;
    errors  = 0;
    pressed = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    tick(3);
    check("reset_col",   32'(kp.col_n),     32'h0E);
    check("reset_bcd",   32'(kp.bcd_data),  32'h10);
    check("reset_valid", 32'(kp.key_valid), 32'h0);
    check("reset_code",  32'(kp.key_code),  32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Idle scanning: one column advance every SCAN_DIV cycles
    prev = kp.col_n;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin tick(1); n++; end while (kp.col_n == prev && n < 20);
      exp_col = {prev[2:0], prev[3]};
      check("col_rotate", 32'(kp.col_n), 32'(exp_col));
      check("col_period", 32'(n), 32'd4);
      prev = kp.col_n;
    end

    // '8' (r2,c1): single pulse, then scanning resumes at c2 after release
    push(4'h8, 5'h08);
    pressed = 16'h0200;
    tick(40);
    check("pulse_8_seen", 32'(sb_q.size()), 32'd0);
    pressed = '0;
    n = 0;
    while (kp.col_n == 4'b1101 && n < 40) begin tick(1); n++; end
    check("resume_c2", 32'(kp.col_n), 32'h0B);
    check("bcd_after_8", 32'(kp.bcd_data), 32'h08);
    tick(2);

    // '5' then '*' then 'B'
    press_expect("pulse_5_seen", 16'h0020, 4'h5, 5'h05);
    press_expect("pulse_star_seen", 16'h1000, 4'hE, 5'h10);
    press_expect("pulse_B_seen", 16'h0080, 4'hB, 5'h10);

    // '3' (r0,c2) with bounce: low 3, high 2, then held
    wait_col_start(4'b1011);
    push(4'h3, 5'h03);
    pressed = 16'h0004;
    tick(3);
    pressed = '0;
    tick(2);
    pressed = 16'h0004;
    tick(40);
    check("pulse_3_seen", 32'(sb_q.size()), 32'd0);
    pressed = '0;
    tick(16);

    // 5-cycle press alone: no pulse, outputs unchanged
    wait_col_start(4'b1011);
    pressed = 16'h0004;
    tick(5);
    pressed = '0;
    tick(40);
    check("short_press_bcd",  32'(kp.bcd_data), 32'h03);
    check("short_press_code", 32'(kp.key_code), 32'h3);

    // '1' and '4' together on c0: lower row wins
    press_expect("pulse_1_seen", 16'h0011, 4'h1, 5'h01);

    // Reset while debouncing '9' (r2,c2)
    wait_col_start(4'b1011);
    pressed = 16'h0400;
    tick(7);
    check("deb_col_held", 32'(kp.col_n), 32'h0B);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_col",   32'(kp.col_n),     32'h0E);
    check("midrst_bcd",   32'(kp.bcd_data),  32'h10);
    check("midrst_valid", 32'(kp.key_valid), 32'h0);
    check("midrst_code",  32'(kp.key_code),  32'h0);
    tick(2);
    push(4'h9, 5'h09);
    @(negedge clk) rst_n = 1'b1;
    tick(40);
    check("pulse_9_seen", 32'(sb_q.size()), 32'd0);
    pressed = '0;
    tick(16);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
